fetch_unit: RTL and testbench

Instruction fetch stage between `inst_mem` and the `CPU` decode path. Owns the program counter, issues word reads to `inst_mem` (synchronous read, one-cycle latency), buffers returned words in a small prefetch queue, and hands instruction/PC pairs to decode over a valid/ready handshake. Takes branch/jump redirects from execute and discards wrong-path words by epoch tagging.

---
 rtl/riscv_pkg.sv | 19 +
 rtl/fetch_unit_if.sv | 26 ++
 rtl/fetch_queue.sv | 68 ++++++
 rtl/fetch_unit.sv | 96 +++++++++
 tb/tb_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: word width, canonical NOP, default
// reset vector and the entry type carried through the fetch queue.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
    logic            misalign;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_incr(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the fetch stage's instruction-memory, redirect and decode-side
// handshake signals; master is the fetch stage, slave is its environment.
interface fetch_if;

  logic                        imem_req;
  logic [riscv_pkg::XLEN-1:0]  imem_addr;
  logic [riscv_pkg::XLEN-1:0]  imem_rdata;
  logic                        redirect_valid;
  logic [riscv_pkg::XLEN-1:0]  redirect_pc;
  logic                        out_valid;
  logic                        out_ready;
  logic [riscv_pkg::XLEN-1:0]  out_inst;
  logic [riscv_pkg::XLEN-1:0]  out_pc;
  logic                        out_misalign;

  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc, out_misalign,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc, out_misalign,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries with push/pop/flush; a push in the flush
// cycle survives as the sole entry of the emptied queue.
module fetch_queue
  import riscv_pkg::*;
#(
  parameter int              QDEPTH   = 2,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             din,
  output fetch_entry_t             head,
  output logic [$clog2(QDEPTH):0]  count
);

  localparam int              PW      = $clog2(QDEPTH);
  localparam logic [PW:0]     FULL    = QDEPTH[PW:0];
  localparam logic [PW-1:0]   PTR_ONE = PW'(1);
  localparam fetch_entry_t    RESET_ENTRY = '{inst: INST_NOP, pc: RESET_PC, misalign: 1'b0};

  fetch_entry_t  mem_q [QDEPTH];
  fetch_entry_t  mem_d [QDEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop && !flush && (count_q != '0);
    push_ok  = push && (flush || (count_q != FULL) || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    // Flush empties by moving the read pointer onto the write pointer.
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = {{PW{1'b0}}, push_ok};
    end else begin
      if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
      count_d = count_q + {{PW{1'b0}}, push_ok} - {{PW{1'b0}}, pop_ok};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= RESET_ENTRY;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < QDEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, epoch-tagged single outstanding imem read,
// prefetch queue to decode. Optional FETCH_MISALIGN_CHECK_EN faults bad targets.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              QDEPTH   = 2
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  localparam int            CW    = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] DEPTH = QDEPTH[CW-1:0];

  logic [XLEN-1:0] pc_q, pc_d, inflight_pc_q, inflight_pc_d, target;
  logic            epoch_q, epoch_d, inflight_q, inflight_d;
  logic            inflight_epoch_q, inflight_epoch_d, halt_q, halt_d;
  logic [CW-1:0]   count, occ;
  fetch_entry_t    head, push_entry;
  logic            req, pop, push, misalign_redirect;

  always_comb begin
`ifdef FETCH_MISALIGN_CHECK_EN
    misalign_redirect = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
    target            = bus.redirect_pc;
`else
    misalign_redirect = 1'b0;
    target            = bus.redirect_pc & ~32'h3;
`endif
    bus.out_valid = (count != '0) && !bus.redirect_valid;
    pop           = bus.out_valid && bus.out_ready;
    // Occupancy after this cycle's pop plus the word still in flight must leave room.
    occ = count + {{(CW-1){1'b0}}, inflight_q} - {{(CW-1){1'b0}}, pop};
    req = !reset && !bus.redirect_valid && !halt_q && (occ < DEPTH);

    push       = inflight_q && (inflight_epoch_q == epoch_q) && !bus.redirect_valid;
    push_entry = '{inst: bus.imem_rdata, pc: inflight_pc_q, misalign: 1'b0};
    if (misalign_redirect) begin
      push       = 1'b1;
      push_entry = '{inst: INST_NOP, pc: bus.redirect_pc, misalign: 1'b1};
    end

    pc_d = pc_q;
    if (bus.redirect_valid) pc_d = target;
    else if (req)           pc_d = pc_incr(pc_q);
    epoch_d          = epoch_q ^ bus.redirect_valid;
    inflight_d       = req;
    inflight_pc_d    = pc_q;
    inflight_epoch_d = epoch_q;
    halt_d           = bus.redirect_valid ? misalign_redirect : halt_q;

    bus.imem_req     = req;
    bus.imem_addr    = pc_q;
    bus.out_inst     = head.inst;
    bus.out_pc       = head.pc;
    // Without the check no entry is ever pushed with misalign set.
    bus.out_misalign = head.misalign;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q             <= RESET_PC;
      epoch_q          <= 1'b0;
      inflight_q       <= 1'b0;
      inflight_epoch_q <= 1'b0;
      halt_q           <= 1'b0;
    end else begin
      pc_q             <= pc_d;
      epoch_q          <= epoch_d;
      inflight_q       <= inflight_d;
      inflight_epoch_q <= inflight_epoch_d;
      halt_q           <= halt_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
  end

  fetch_queue #(
    .QDEPTH   (QDEPTH),
    .RESET_PC (RESET_PC)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (push_entry),
    .head  (head),
    .count (count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing steps plus a random phase, checked
// against a sequential-PC scoreboard and an occupancy bound.
module tb_fetch_unit;

  localparam int          QDEPTH = 2;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_if bus();

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic        s_valid, s_req, s_mis;
  logic [31:0] s_addr, s_pc, s_inst;

  logic [31:0] exp_pc, fetch_pc;
  int          outstanding, hs_count;
  bit          halted, fault_pending;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  always @(posedge clk) if (bus.imem_req) bus.imem_rdata <= memw(bus.imem_addr);

  function automatic bit is_fault(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
    return t[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at negedge, update the scoreboard, return just after posedge.
  task automatic cyc();
    logic hs;
    @(negedge clk);
    s_valid = bus.out_valid;
    s_req   = bus.imem_req;
    s_mis   = bus.out_misalign;
    s_addr  = bus.imem_addr;
    s_pc    = bus.out_pc;
    s_inst  = bus.out_inst;
    if (reset) begin
      exp_pc = 32'h0; fetch_pc = 32'h0; outstanding = 0;
      halted = 1'b0; fault_pending = 1'b0;
    end else begin
      hs = s_valid && bus.out_ready;
      if (bus.redirect_valid) check("valid_during_redirect", s_valid, 0);
      if (halted) check("req_while_halted", s_req, 0);
      if (s_req) begin
        check("req_addr", s_addr, fetch_pc);
        fetch_pc += 32'd4;
        outstanding++;
      end
      if (hs) begin
        hs_count++;
        if (fault_pending) begin
          check("fault_pc", s_pc, exp_pc);
          check("fault_flag", s_mis, 1);
          check("fault_inst", s_inst, NOP);
          fault_pending = 1'b0;
        end else begin
          check("out_pc", s_pc, exp_pc);
          check("out_inst", s_inst, memw(exp_pc));
          check("out_misalign", s_mis, 0);
          exp_pc += 32'd4;
        end
        outstanding--;
      end
      check("occupancy_bound", outstanding <= QDEPTH, 1);
      if (bus.redirect_valid) begin
        if (is_fault(bus.redirect_pc)) begin
          fault_pending = 1'b1; halted = 1'b1;
          exp_pc = bus.redirect_pc; outstanding = 1;
        end else begin
          fault_pending = 1'b0; halted = 1'b0;
          exp_pc = bus.redirect_pc & ~32'h3; fetch_pc = exp_pc; outstanding = 0;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] held, rp;
    bit          ok;
    int          hs0;

    hs_count           = 0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    repeat (3) cyc();
    check("rst_req",   s_req,   0);
    check("rst_addr",  s_addr,  32'h0);
    check("rst_valid", s_valid, 0);
    check("rst_inst",  s_inst,  NOP);
    check("rst_pc",    s_pc,    32'h0);
    check("rst_mis",   s_mis,   0);

    // Release reset with decode always ready: stream from PC 0.
    bus.out_ready = 1'b1;
    reset = 1'b0;
    cyc();
    check("first_req",  s_req,  1);
    check("first_addr", s_addr, 32'h0);
    cyc();
    check("lat_valid_c1", s_valid, 0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("stream_valid", s_valid, 1);
      check("stream_pc",    s_pc,    32'(4 * i));
      check("stream_inst",  s_inst,  memw(32'(4 * i)));
    end

    // Back-pressure for 10 cycles: queue fills and holds.
    bus.out_ready = 1'b0;
    cyc();
    held = s_pc;
    check("stall_first_pc", held, 32'd24);
    repeat (9) cyc();
    check("stall_req",   s_req,   0);
    check("stall_valid", s_valid, 1);
    check("stall_head",  s_pc,    held);
    check("stall_occ",   outstanding, QDEPTH);

    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check("release_valid", s_valid, 1);
      check("release_pc",    s_pc,    held + 32'(4 * i));
    end

    // Refill, then redirect while full.
    bus.out_ready = 1'b0;
    repeat (3) cyc();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0100;
    cyc();
    check("redir_gate", s_valid, 0);
    bus.redirect_valid = 1'b0; bus.out_ready = 1'b1;
    cyc();
    check("redir_req",   s_req,   1);
    check("redir_addr",  s_addr,  32'h100);
    check("redir_low1",  s_valid, 0);
    cyc();
    check("redir_low2",  s_valid, 0);
    cyc();
    check("redir_valid", s_valid, 1);
    check("redir_pc",    s_pc,    32'h100);
    cyc();

    // Redirect with decode ready and a non-empty queue: no handshake.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0300;
    cyc();
    check("redir2_nopop", s_valid, 0);
    bus.redirect_valid = 1'b0;
    cyc(); cyc(); cyc();
    check("redir2_valid", s_valid, 1);
    check("redir2_pc",    s_pc,    32'h300);

    // Address wrap at the top of memory.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    cyc();
    bus.redirect_valid = 1'b0;
    cyc(); cyc();
    cyc(); check("wrap_pc0", s_pc, 32'hFFFF_FFF8); check("wrap_v0", s_valid, 1);
    cyc(); check("wrap_pc1", s_pc, 32'hFFFF_FFFC); check("wrap_v1", s_valid, 1);
    cyc(); check("wrap_pc2", s_pc, 32'h0000_0000); check("wrap_v2", s_valid, 1);

    // Misaligned redirect target.
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0102;
    cyc();
    bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    cyc();
    check("mis_valid", s_valid, 1);
    check("mis_flag",  s_mis,   1);
    check("mis_pc",    s_pc,    32'h102);
    check("mis_inst",  s_inst,  NOP);
    check("mis_req",   s_req,   0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("halt_req",   s_req,   0);
      check("halt_valid", s_valid, 0);
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0200;
    cyc();
    bus.redirect_valid = 1'b0;
    cyc();
    check("resume_req",  s_req,  1);
    check("resume_addr", s_addr, 32'h200);
    cyc(); cyc();
    check("resume_valid", s_valid, 1);
    check("resume_pc",    s_pc,    32'h200);
`else
    cyc();
    check("align_req",  s_req,  1);
    check("align_addr", s_addr, 32'h100);
    cyc(); cyc();
    check("align_valid", s_valid, 1);
    check("align_pc",    s_pc,    32'h100);
    check("align_mis",   s_mis,   0);
`endif

    // Random back-pressure and redirects against the scoreboard.
    hs0 = hs_count;
    for (int i = 0; i < 600; i++) begin
      bus.out_ready      = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      rp = $urandom;
      if ($urandom_range(0, 3) != 0) rp[1:0] = 2'b00;
      bus.redirect_pc = rp;
      cyc();
    end
    check("random_progress", (hs_count - hs0) > 60, 1);

    // Asynchronous reset in the middle of streaming.
    bus.redirect_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (5) cyc();
    reset = 1'b1;
    #1;
    check("midrst_valid", bus.out_valid, 0);
    check("midrst_req",   bus.imem_req,  0);
    check("midrst_addr",  bus.imem_addr, 32'h0);
    check("midrst_pc",    bus.out_pc,    32'h0);
    check("midrst_inst",  bus.out_inst,  NOP);
    cyc();
    reset = 1'b0;
    cyc();
    check("midrst_first_req", s_req, 1);
    ok = 1'b0;
    for (int k = 0; k < 6 && !ok; k++) begin
      cyc();
      ok = s_valid;
    end
    check("midrst_valid_timeout", ok, 1);
    check("midrst_first_pc", s_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
